// File: rtl/pico_io_pkg.sv
// rtl/pico_io_pkg.sv - shared address map and irq state encoding for pico_io_hub
package pico_io_pkg;

  localparam logic [7:0] OUT_BASE   = 8'h00;
  localparam logic [7:0] IN_BASE    = 8'h40;
  localparam logic [7:0] IRQ_PEND_A = 8'h80;
  localparam logic [7:0] IRQ_MASK_A = 8'h81;
  localparam logic [7:0] IRQ_ID_A   = 8'h82;
  localparam logic [7:0] IRQ_NONE   = 8'hFF;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_REQ,
    IRQ_SERV
  } irq_state_e;

endpackage

// File: rtl/pico_irq_ctrl.sv
// rtl/pico_irq_ctrl.sv - edge-latched pending/mask registers, lowest-index id and request/service fsm
module pico_irq_ctrl
  import pico_io_pkg::*;
#(
  parameter int N_IRQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic             interrupt_ack,
  input  logic             pend_we,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] wdata,
  output logic [N_IRQ-1:0] pend,
  output logic [N_IRQ-1:0] mask,
  output logic [7:0]       irq_id,
  output logic             interrupt
);

  irq_state_e       state, state_n;
  logic [N_IRQ-1:0] irq_d;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] active;
  logic [N_IRQ-1:0] clr;

  assign rise   = irq_src & ~irq_d;
  assign active = pend & mask;
  assign clr    = pend_we ? wdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_d <= '0;
      pend  <= '0;
      mask  <= '0;
      state <= IRQ_IDLE;
    end else begin
      irq_d <= irq_src;
      // a fresh edge beats a simultaneous write-1-to-clear on the same bit
      pend  <= rise | (pend & ~clr);
      if (mask_we) mask <= wdata;
      state <= state_n;
    end
  end

  always_comb begin
    irq_id = IRQ_NONE;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (active[i]) irq_id = 8'(i);
    end
  end

  always_comb begin
    state_n   = state;
    interrupt = 1'b0;
    case (state)
      IRQ_IDLE: if (|active) state_n = IRQ_REQ;
      IRQ_REQ: begin
        interrupt = 1'b1;
        if (interrupt_ack)  state_n = IRQ_SERV;
        else if (!(|active)) state_n = IRQ_IDLE;
      end
      IRQ_SERV: if (pend_we) state_n = IRQ_IDLE;
      default:  state_n = IRQ_IDLE;
    endcase
  end

endmodule

// File: rtl/pico_io_hub.sv
// rtl/pico_io_hub.sv - kcpsm6 port decode, output registers, registered read mux and irq hub
// Optional input synchronizers on irq_src/in_chans: PICO_IO_HUB_SYNC_EN
module pico_io_hub
  import pico_io_pkg::*;
#(
  parameter int         N_OUT   = 4,
  parameter int         N_IN    = 4,
  parameter int         N_IRQ   = 4,
  parameter logic [7:0] OUT_RST = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         port_id,
  input  logic [7:0]         out_port,
  input  logic               write_strobe,
  input  logic               k_write_strobe,
  input  logic               read_strobe,
  output logic [7:0]         in_port,
  output logic               interrupt,
  input  logic               interrupt_ack,
  output logic [8*N_OUT-1:0] out_regs,
  input  logic [8*N_IN-1:0]  in_chans,
  input  logic [N_IRQ-1:0]   irq_src
);

  logic [N_OUT-1:0][7:0] out_q;
  logic [8*N_IN-1:0]     in_sync;
  logic [N_IRQ-1:0]      irq_sync;
  logic [N_IRQ-1:0]      pend, mask;
  logic [7:0]            irq_id;
  logic [7:0]            rd_data;
  logic                  pend_we, mask_we;

  // reads have no side effects, so the strobe is intentionally left unconnected
  logic unused_read_strobe;
  assign unused_read_strobe = read_strobe;

`ifdef PICO_IO_HUB_SYNC_EN
  logic [8*N_IN-1:0] in_s1, in_s2;
  logic [N_IRQ-1:0]  irq_s1, irq_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_s1  <= '0;
      in_s2  <= '0;
      irq_s1 <= '0;
      irq_s2 <= '0;
    end else begin
      in_s1  <= in_chans;
      in_s2  <= in_s1;
      irq_s1 <= irq_src;
      irq_s2 <= irq_s1;
    end
  end

  assign in_sync  = in_s2;
  assign irq_sync = irq_s2;
`else
  assign in_sync  = in_chans;
  assign irq_sync = irq_src;
`endif

  assign out_regs = out_q;
  assign pend_we  = write_strobe && (port_id == IRQ_PEND_A);
  assign mask_we  = write_strobe && (port_id == IRQ_MASK_A);

  // OUTPUTK only carries a 4-bit port, so it reaches the output bank alone
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= {N_OUT{OUT_RST}};
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (write_strobe && (port_id == OUT_BASE + 8'(i)))
          out_q[i] <= out_port;
        else if (k_write_strobe && (port_id[3:0] == 4'(i)))
          out_q[i] <= out_port;
      end
    end
  end

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < N_OUT; i++) begin
      if (port_id == OUT_BASE + 8'(i)) rd_data = out_q[i];
    end
    for (int j = 0; j < N_IN; j++) begin
      if (port_id == IN_BASE + 8'(j)) rd_data = in_sync[8*j +: 8];
    end
    if (port_id == IRQ_PEND_A) rd_data = 8'(pend);
    if (port_id == IRQ_MASK_A) rd_data = 8'(mask);
    if (port_id == IRQ_ID_A)   rd_data = irq_id;
  end

  always_ff @(posedge clk) begin
    if (reset) in_port <= 8'h00;
    else       in_port <= rd_data;
  end

  pico_irq_ctrl #(
    .N_IRQ(N_IRQ)
  ) u_irq (
    .clk          (clk),
    .reset        (reset),
    .irq_src      (irq_sync),
    .interrupt_ack(interrupt_ack),
    .pend_we      (pend_we),
    .mask_we      (mask_we),
    .wdata        (out_port[N_IRQ-1:0]),
    .pend         (pend),
    .mask         (mask),
    .irq_id       (irq_id),
    .interrupt    (interrupt)
  );

endmodule

// File: tb/tb_pico_io_hub.sv
// tb/tb_pico_io_hub.sv - directed self-checking bench for pico_io_hub (default build)
module tb_pico_io_hub;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  port_id, out_port;
  logic        write_strobe, k_write_strobe, read_strobe;
  logic [7:0]  in_port;
  logic        interrupt, interrupt_ack;
  logic [31:0] out_regs;
  logic [31:0] in_chans;
  logic [3:0]  irq_src;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pico_io_hub #(
    .N_OUT(4), .N_IN(4), .N_IRQ(4), .OUT_RST(8'h5A)
  ) dut (
    .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .k_write_strobe(k_write_strobe),
    .read_strobe(read_strobe), .in_port(in_port), .interrupt(interrupt),
    .interrupt_ack(interrupt_ack), .out_regs(out_regs), .in_chans(in_chans),
    .irq_src(irq_src)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_id = a; out_port = d; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    port_id = a; read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
    check(tag, {24'h0, in_port}, {24'h0, exp});
  endtask

  initial begin
    reset = 1'b1; port_id = 8'h00; out_port = 8'h00;
    write_strobe = 1'b0; k_write_strobe = 1'b0; read_strobe = 1'b0;
    interrupt_ack = 1'b0; irq_src = 4'h0; in_chans = 32'h43424140;
    cyc(3);
    check("rst_in_port", {24'h0, in_port}, 32'h0);
    check("rst_out_regs", out_regs, 32'h5A5A5A5A);
    check("rst_interrupt", {31'h0, interrupt}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) rd_chk("rst_out_rd", 8'(i), 8'h5A);
    rd_chk("rst_pend", 8'h80, 8'h00);
    rd_chk("rst_mask", 8'h81, 8'h00);
    rd_chk("rst_id", 8'h82, 8'hFF);

    // OUTPUT then OUTPUTK, each visible one cycle after its strobe
    wr(8'h02, 8'hA5);
    check("out2_write", {24'h0, out_regs[23:16]}, 32'hA5);
    port_id = 8'h01; out_port = 8'h3C; k_write_strobe = 1'b1;
    @(negedge clk);
    k_write_strobe = 1'b0;
    check("k_out1_write", {24'h0, out_regs[15:8]}, 32'h3C);
    port_id = 8'h0F; out_port = 8'h77; k_write_strobe = 1'b1;
    @(negedge clk);
    k_write_strobe = 1'b0;
    check("k_out_f_ignored", out_regs, 32'h5AA53C5A);
    wr(8'h04, 8'h11);
    check("out4_unmapped", out_regs, 32'h5AA53C5A);
    rd_chk("out2_readback", 8'h02, 8'hA5);

    // read mux
    port_id = 8'h43;
    @(negedge clk);
    check("in3_cycle2", {24'h0, in_port}, 32'h43);
    @(negedge clk);
    check("in3_held", {24'h0, in_port}, 32'h43);
    rd_chk("in0", 8'h40, 8'h40);
    rd_chk("in4_unmapped", 8'h44, 8'h00);
    rd_chk("unmapped_7f", 8'h7F, 8'h00);
    rd_chk("unmapped_83", 8'h83, 8'h00);

    // priority id, ack, and re-request after W1C
    wr(8'h81, 8'h06);
    rd_chk("mask_rd", 8'h81, 8'h06);
    irq_src = 4'b0100; @(negedge clk);
    irq_src = 4'b0010; @(negedge clk);
    irq_src = 4'b0000; cyc(2);
    rd_chk("pend_06", 8'h80, 8'h06);
    rd_chk("id_01", 8'h82, 8'h01);
    check("irq_req", {31'h0, interrupt}, 32'h1);
    interrupt_ack = 1'b1; @(negedge clk); interrupt_ack = 1'b0;
    check("irq_serv", {31'h0, interrupt}, 32'h0);
    cyc(2);
    check("irq_serv_hold", {31'h0, interrupt}, 32'h0);
    wr(8'h80, 8'h02);
    check("irq_idle_after_w1c", {31'h0, interrupt}, 32'h0);
    @(negedge clk);
    check("irq_rereq", {31'h0, interrupt}, 32'h1);
    rd_chk("id_02", 8'h82, 8'h02);
    rd_chk("pend_04", 8'h80, 8'h04);

    // clearing the only active source drops the request
    wr(8'h80, 8'h0F);
    cyc(1);
    check("req_drop_on_clear", {31'h0, interrupt}, 32'h0);
    rd_chk("id_none", 8'h82, 8'hFF);

    // edge and W1C on the same bit in the same cycle: edge wins; mask 0 blocks request
    wr(8'h81, 8'h00);
    irq_src = 4'b0001; port_id = 8'h80; out_port = 8'h01; write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
    cyc(2);
    rd_chk("pend_set_wins", 8'h80, 8'h01);
    check("masked_no_irq", {31'h0, interrupt}, 32'h0);

    // unmasking requests, re-masking before ack withdraws it
    wr(8'h81, 8'h01);
    @(negedge clk);
    check("unmask_req", {31'h0, interrupt}, 32'h1);
    wr(8'h81, 8'h00);
    @(negedge clk);
    check("remask_drop", {31'h0, interrupt}, 32'h0);

    // reset while in service
    wr(8'h81, 8'h01);
    @(negedge clk);
    interrupt_ack = 1'b1; @(negedge clk); interrupt_ack = 1'b0;
    check("serv_before_rst", {31'h0, interrupt}, 32'h0);
    reset = 1'b1; irq_src = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    check("rst2_interrupt", {31'h0, interrupt}, 32'h0);
    check("rst2_out_regs", out_regs, 32'h5A5A5A5A);
    rd_chk("rst2_pend", 8'h80, 8'h00);
    rd_chk("rst2_mask", 8'h81, 8'h00);
    wr(8'h81, 8'h0F);
    cyc(2);
    check("rst2_idle", {31'h0, interrupt}, 32'h0);
    rd_chk("rst2_id", 8'h82, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
